// File: rtl/increment.sv
// Registered WIDTH-bit incrementer built on an explicit half-adder ripple chain.
// Define INCREMENT_SAT_EN to clamp all-ones at all-ones instead of wrapping to zero.

module increment_ha (
    input  logic a,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ cin;
    assign cout = a & cin;
endmodule

module increment #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Incremented_result,
    output logic             out_valid,
    output logic             carry_out,
    output logic             result_zero
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] nxt;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        increment_ha u_ha (
            .a    (A[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

`ifdef INCREMENT_SAT_EN
    // A carry out of the MSB only happens for all-ones, so clamp there.
    assign nxt = c[WIDTH] ? {WIDTH{1'b1}} : sum;
`else
    assign nxt = sum;
`endif

    // Data registers load only on in_valid so an undriven A cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Incremented_result <= '0;
            out_valid          <= 1'b0;
            carry_out          <= 1'b0;
            result_zero        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Incremented_result <= nxt;
                carry_out          <= c[WIDTH];
                result_zero        <= (nxt == '0);
            end
        end
    end
endmodule

// File: tb/tb_increment.sv
// Scoreboard bench for increment: directed operands push hand-computed results,
// a negedge monitor pops and compares whenever out_valid is presented.

module tb_increment;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         z;
        int           due;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] Incremented_result;
    logic         out_valid;
    logic         carry_out;
    logic         result_zero;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];

    increment #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .A                  (A),
        .Incremented_result (Incremented_result),
        .out_valid          (out_valid),
        .carry_out          (carry_out),
        .result_zero        (result_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] er, input logic ec, input logic ez);
        exp_t e;
        @(posedge clk);
        #1;
        A        = a;
        in_valid = 1'b1;
        e.res = er;
        e.cy  = ec;
        e.z   = ez;
        e.due = cyc + 1;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 'x;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_res"}, 64'(Incremented_result), 64'h0);
        chk({tag, "_vld"}, 64'(out_valid), 64'h0);
        chk({tag, "_cy"},  64'(carry_out), 64'h0);
        chk({tag, "_z"},   64'(result_zero), 64'h0);
    endtask

    // Monitor: every out_valid must match the head entry, due on exactly this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'h0);
                end else begin
                    e = q.pop_front();
                    chk("due_cycle", 64'(cyc), 64'(e.due));
                    chk("result",    64'(Incremented_result), 64'(e.res));
                    chk("carry_out", 64'(carry_out), 64'(e.cy));
                    chk("result_z",  64'(result_zero), 64'(e.z));
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("missing_out", 64'(out_valid), 64'h1);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");

        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_release_vld", 64'(out_valid), 64'h0);

        send(8'b0011_0011, 8'b0011_0100, 1'b0, 1'b0);
        send(8'b0011_1100, 8'b0011_1101, 1'b0, 1'b0);
        send(8'h7F, 8'h80, 1'b0, 1'b0);
        send(8'h0F, 8'h10, 1'b0, 1'b0);
`ifdef INCREMENT_SAT_EN
        send(8'hFF, 8'hFF, 1'b1, 1'b0);
`else
        send(8'hFF, 8'h00, 1'b1, 1'b1);
`endif
        send(8'hFE, 8'hFF, 1'b0, 1'b0);
        idle();
        idle();

        send(8'h00, 8'h01, 1'b0, 1'b0);
        send(8'h01, 8'h02, 1'b0, 1'b0);
        send(8'h02, 8'h03, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #1;
        chk("hold_vld", 64'(out_valid), 64'h0);
        chk("hold_res", 64'(Incremented_result), 64'h03);
        chk("hold_cy",  64'(carry_out), 64'h0);
        repeat (2) idle();

        // Mid-stream reset with a result on the outputs, then an operand during reset.
        send(8'h41, 8'h42, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        q.delete();
        A        = 8'h09;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 'x;
        rst_n    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("after_rst_vld", 64'(out_valid), 64'h0);
        chk("after_rst_res", 64'(Incremented_result), 64'h0);

        send(8'h80, 8'h81, 1'b0, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
